// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if: command/status bundle between the RAS controller and the RAS.
interface ras_ctrl_if;
    logic        push;
    logic        pop;
    logic [31:0] new_entry;
    logic        is_branch;
    logic        branch_resolved;
    logic        must_flush;
    logic [31:0] ras_top;
    logic        ras_empty;
    modport master (
        output push, pop, new_entry, is_branch, branch_resolved, must_flush,
        input  ras_top, ras_empty
    );
    modport slave (
        input  push, pop, new_entry, is_branch, branch_resolved, must_flush,
        output ras_top, ras_empty
    );
endinterface

// File: rtl/ras_ctrl.sv
// ras_ctrl: decodes fetched calls/returns into RAS commands and bounds outstanding checkpoints.
module ras_ctrl #(
    parameter int SIZE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        resolved_i,
    ras_ctrl_if.master  ras,
    output logic        pred_valid_o,
    output logic [31:0] pred_target_o
);
    localparam int CW = $clog2(SIZE) + 1;
    typedef enum logic [1:0] {IDLE, SWAP_PUSH, SWAP_END} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count;
    logic [6:0] opcode;
    logic [4:0] rd, rs1;
    logic is_jal, is_jalr, is_br, ckpt, link_rd, link_rs1;
    logic do_push, do_pop, do_swap, accept, ckpt_acc;
    logic push_q, pop_q, is_branch_q;
    logic [31:0] new_entry_q;
    logic unused_bits;
    assign opcode      = instr_i[6:0];
    assign rd          = instr_i[11:7];
    assign rs1         = instr_i[19:15];
    assign unused_bits = ^instr_i[31:20];
    assign is_jal   = opcode == 7'b1101111;
    assign is_jalr  = opcode == 7'b1100111 && instr_i[14:12] == 3'b000;
    assign is_br    = opcode == 7'b1100011;
    assign ckpt     = is_br || opcode == 7'b1100111;
    assign link_rd  = rd == 5'd1 || rd == 5'd5;
    assign link_rs1 = rs1 == 5'd1 || rs1 == 5'd5;
    assign do_push  = (is_jal && link_rd) || (is_jalr && link_rd && (!link_rs1 || rd == rs1));
    assign do_pop   = is_jalr && !link_rd && link_rs1;
    assign do_swap  = is_jalr && link_rd && link_rs1 && rd != rs1;
    // A full checkpoint FIFO stalls only checkpoint instructions; no same-cycle resolve bypass.
    assign ready_o  = state == IDLE && !(ckpt && count == CW'(SIZE));
    assign accept   = valid_i && ready_o && !flush_i;
    assign ckpt_acc = accept && ckpt;
    assign ras.branch_resolved = resolved_i && count != '0;
    assign ras.must_flush      = flush_i;
    assign ras.push            = push_q;
    assign ras.pop             = pop_q && !ras.ras_empty;
    assign ras.is_branch       = is_branch_q;
    assign ras.new_entry       = new_entry_q;
    assign pred_valid_o        = ras.pop;
    assign pred_target_o       = ras.pop ? ras.ras_top : '0;
    always_comb begin
        state_nx = state;
        if (flush_i)
            state_nx = IDLE;
        else if (state == IDLE)
            state_nx = accept && do_swap ? SWAP_PUSH : IDLE;
        else
            state_nx = state == SWAP_PUSH ? SWAP_END : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // Swap: pop goes out first, the push of the stored return address follows a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            is_branch_q <= 1'b0;
            new_entry_q <= '0;
            count       <= '0;
        end else begin
            push_q      <= !flush_i && ((accept && do_push) || state == SWAP_PUSH);
            pop_q       <= !flush_i && accept && (do_pop || do_swap);
            is_branch_q <= !flush_i && ckpt_acc;
            new_entry_q <= accept ? pc_i + 32'd4 : new_entry_q;
            count       <= flush_i ? '0 : count + CW'(ckpt_acc) - CW'(ras.branch_resolved);
        end
    end
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed checks of decode, swap sequencing, checkpoint stall and flush.
module tb_ras_ctrl;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] JAL_X1    = 32'h0000_00EF;
    localparam logic [31:0] JALR_RET  = 32'h0000_8067;
    localparam logic [31:0] JALR_SWAP = 32'h0000_82E7;
    localparam logic [31:0] BEQ       = 32'h0000_0063;
    logic        clk = 1'b0;
    logic        rst_n, valid, ready, flush, resolved, pred_valid;
    logic [31:0] instr, pc, pred_target;
    int checks = 0;
    int errors = 0;
    ras_ctrl_if bus ();
    ras_ctrl #(.SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready),
        .instr_i(instr), .pc_i(pc), .flush_i(flush), .resolved_i(resolved),
        .ras(bus.master), .pred_valid_o(pred_valid), .pred_target_o(pred_target)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic resolve_one();
        resolved = 1'b1;
        #1 chk("resolve_pulse", bus.branch_resolved, 1);
        step();
        chk("resolve_empty", bus.branch_resolved, 0);
        resolved = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0; valid = 1'b0; instr = NOP; pc = '0; flush = 1'b0; resolved = 1'b0;
        bus.ras_top = 32'h104; bus.ras_empty = 1'b1;
        step(); step();
        chk("rst_push", bus.push, 0);
        chk("rst_pop", bus.pop, 0);
        chk("rst_isbr", bus.is_branch, 0);
        chk("rst_pvalid", pred_valid, 0);
        chk("rst_entry", bus.new_entry, 0);
        chk("rst_ptarget", pred_target, 0);
        chk("rst_ready", ready, 1);
        rst_n = 1'b1;
        step();
        valid = 1'b1; instr = JAL_X1; pc = 32'h100;
        step();
        valid = 1'b0; instr = NOP;
        chk("jal_push", bus.push, 1);
        chk("jal_entry", bus.new_entry, 32'h104);
        chk("jal_isbr", bus.is_branch, 0);
        chk("jal_pop", bus.pop, 0);
        step();
        chk("jal_push_once", bus.push, 0);
        bus.ras_empty = 1'b0;
        valid = 1'b1; instr = JALR_RET; pc = 32'h300;
        step();
        valid = 1'b0; instr = NOP;
        chk("ret_pop", bus.pop, 1);
        chk("ret_pvalid", pred_valid, 1);
        chk("ret_ptarget", pred_target, 32'h104);
        chk("ret_isbr", bus.is_branch, 1);
        chk("ret_push", bus.push, 0);
        resolve_one();
        bus.ras_empty = 1'b1;
        valid = 1'b1; instr = JALR_RET;
        step();
        valid = 1'b0; instr = NOP;
        chk("ret_empty_pop", bus.pop, 0);
        chk("ret_empty_pvalid", pred_valid, 0);
        chk("ret_empty_isbr", bus.is_branch, 1);
        resolve_one();
        bus.ras_empty = 1'b0;
        valid = 1'b1; instr = JALR_SWAP; pc = 32'h200;
        step();
        valid = 1'b0; instr = NOP;
        chk("swap1_pop", bus.pop, 1);
        chk("swap1_push", bus.push, 0);
        chk("swap1_ready", ready, 0);
        step();
        chk("swap2_push", bus.push, 1);
        chk("swap2_entry", bus.new_entry, 32'h204);
        chk("swap2_pop", bus.pop, 0);
        chk("swap2_ready", ready, 0);
        step();
        chk("swap3_ready", ready, 1);
        chk("swap3_push", bus.push, 0);
        resolve_one();
        valid = 1'b1; instr = BEQ;
        for (int i = 0; i < 8; i++) begin
            #1 chk("beq_ready", ready, 1);
            step();
        end
        chk("beq_full_ready", ready, 0);
        resolved = 1'b1;
        #1 chk("full_resolve", bus.branch_resolved, 1);
        chk("full_no_bypass", ready, 0);
        valid = 1'b0;
        step();
        resolved = 1'b0;
        #1 chk("full_after_resolve", ready, 1);
        flush = 1'b1;
        #1 chk("flush_must", bus.must_flush, 1);
        step();
        flush = 1'b0; resolved = 1'b1;
        #1 chk("flush_count_zero", bus.branch_resolved, 0);
        resolved = 1'b0;
        valid = 1'b1; instr = JAL_X1; pc = 32'h400; flush = 1'b1;
        step();
        valid = 1'b0; instr = NOP; flush = 1'b0;
        chk("flush_drop_push", bus.push, 0);
        valid = 1'b1; instr = JALR_SWAP; pc = 32'h500;
        step();
        valid = 1'b0; instr = NOP; flush = 1'b1;
        #1 chk("fswap_pop", bus.pop, 1);
        chk("fswap_must", bus.must_flush, 1);
        step();
        flush = 1'b0;
        chk("fswap_no_push", bus.push, 0);
        chk("fswap_pop_off", bus.pop, 0);
        chk("fswap_ready", ready, 1);
        resolved = 1'b1;
        #1 chk("fswap_count_zero", bus.branch_resolved, 0);
        resolved = 1'b0;
        step();
        chk("fswap_still_no_push", bus.push, 0);
        valid = 1'b1; instr = JALR_SWAP; pc = 32'h600;
        step();
        valid = 1'b0; instr = NOP;
        chk("rswap_ready", ready, 0);
        rst_n = 1'b0;
        #1 chk("rswap_rst_ready", ready, 1);
        chk("rswap_rst_pop", bus.pop, 0);
        chk("rswap_rst_entry", bus.new_entry, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rswap_no_push", bus.push, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Producer side of the return address stack: decodes each fetched 32-bit instruction and drives the RAS command interface (push, pop, new_entry, is_branch, branch_resolved, must_flush).
- Sits between fetch/predecode and the RAS instance.
- Tracks unresolved checkpointed branches so the RAS checkpoint FIFO never overflows.
- Sequences the pop-then-push "coroutine swap" case over two cycles, because the RAS ignores pop when push is asserted in the same cycle.

Parameters:
- SIZE, 8, RAS depth and checkpoint FIFO depth; also the maximum number of outstanding checkpointed branches.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- valid_i  input  1  fetch instruction valid
- ready_o  output  1  instruction accepted when valid_i & ready_o
- instr_i  input  32  fetched instruction
- pc_i  input  32  PC of instr_i
- flush_i  input  1  pipeline flush (mispredict)
- resolved_i  input  1  execute stage resolved the oldest checkpointed branch
- ras_top_i  input  32  RAS pc_out
- ras_empty_i  input  1  RAS is_empty
- push_o  output  1  to RAS push
- pop_o  output  1  to RAS pop
- new_entry_o  output  32  to RAS new_entry
- is_branch_o  output  1  to RAS is_branch (checkpoint)
- branch_resolved_o  output  1  to RAS branch_resolved
- must_flush_o  output  1  to RAS must_flush
- pred_valid_o  output  1  return-target prediction valid
- pred_target_o  output  32  predicted return target

Behaviour:
- Reset values: push_o, pop_o, is_branch_o, pred_valid_o = 0; new_entry_o, pred_target_o = 0; FSM = IDLE; outstanding count = 0.
- Decode (combinational on instr_i):
  - link(r) = (r==1 || r==5).
  - JAL (opcode 1101111): push if link(rd).
  - JALR (opcode 1100111, funct3 000):
    - !link(rd) & !link(rs1): no RAS action.
    - !link(rd) & link(rs1): pop.
    - link(rd) & !link(rs1): push.
    - link(rd) & link(rs1) & rd==rs1: push.
    - link(rd) & link(rs1) & rd!=rs1: swap.
  - Checkpoint instruction: BRANCH (opcode 1100011) or any JALR.
- Latency: all RAS command outputs are registered, asserted in the cycle after acceptance and held for exactly one cycle.
- new_entry_o = pc_i + 4, modulo 2^32.
- Pop suppression: pop_o is asserted only if ras_empty_i = 0, sampled in the cycle pop_o would assert. When suppressed, pred_valid_o = 0.
- Prediction: pred_valid_o = pop_o. pred_target_o = ras_top_i, passed combinationally in that cycle, before the pop takes effect.
- FSM:
  - IDLE: accept when ready_o. A swap asserts pop_o (and is_branch_o) next cycle, then moves to SWAP_PUSH.
  - SWAP_PUSH: push_o = 1 with the stored new_entry_o; ready_o = 0; returns to IDLE after one cycle.
- Outstanding counter, width clog2(SIZE)+1:
  - Increments on acceptance of a checkpoint instruction.
  - Decrements on branch_resolved_o.
  - Both in the same cycle: unchanged.
- branch_resolved_o = resolved_i & (count != 0), combinational.
- Stall rule: ready_o = 0 when FSM = SWAP_PUSH, or when instr_i is a checkpoint instruction and count == SIZE (no bypass from a same-cycle resolved_i).
- must_flush_o = flush_i, combinational.
- Flush handling, on a cycle with flush_i = 1:
  - Next cycle: push_o, pop_o, is_branch_o, pred_valid_o = 0.
  - FSM returns to IDLE, aborting any pending swap push.
  - count = 0.
  - The instruction presented that cycle is dropped (not accepted); flush wins over resolve.
- Reset asserted mid-swap returns all state to reset values immediately.

Test Plan:
- JAL x1 at pc 0x100 -> next cycle push_o=1, new_entry_o=0x104, is_branch_o=0.
- JALR x0,0(x1) with RAS holding 0x104 -> next cycle pop_o=1, pred_valid_o=1, pred_target_o=0x104.
- JALR x0,0(x1) with ras_empty_i=1 -> pop_o=0, pred_valid_o=0, is_branch_o=1.
- JALR x5,0(x1) at pc 0x200 -> cycle+1: pop_o=1, ready_o=0; cycle+2: push_o=1, new_entry_o=0x204; cycle+3: ready_o=1.
- SIZE=8; 8 BEQs accepted without resolve -> 9th BEQ sees ready_o=0. One resolved_i -> branch_resolved_o=1, next cycle ready_o=1.
- Swap accepted, flush_i in the SWAP_PUSH cycle -> no push_o follows, must_flush_o=1, count=0, ready_o=1 next cycle.
